mult_datapath: RTL and testbench

Shift-add datapath for the sequential signed multiplier. It responds to the strobes issued by the multiplier control unit (`load`, `reg_en`, `shift_en`, `psel`) and returns the status the controller branches on (`z_flag_multiplicand`, `lsb_multiplicand`). It holds operand magnitudes, a running product and the result sign, and drives the signed result toward the display path.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_datapath_if.sv | 29 ++
 rtl/mult_abs.sv | 12 +
 rtl/mult_datapath.sv | 80 ++++++++
 tb/tb_mult_datapath.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: operand width,
// product width helper and the controller state encoding.
package mult_pkg;

    localparam int WIDTH = 8;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Controller states, kept here so the controller and datapath agree on one encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/mult_datapath_if.sv
// Strobe/status/operand bundle between the multiplier controller (master)
// and the shift-add datapath (slave).
interface mult_datapath_if
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
);
    logic [WIDTH-1:0]             multiplicand;
    logic [WIDTH-1:0]             multiplier;
    logic                         load;
    logic                         reg_en;
    logic                         shift_en;
    logic                         psel;
    logic                         z_flag_multiplicand;
    logic                         lsb_multiplicand;
    logic [prod_width(WIDTH)-1:0] result;
    logic [7:0]                   step_count;

    modport master (
        output multiplicand, multiplier, load, reg_en, shift_en, psel,
        input  z_flag_multiplicand, lsb_multiplicand, result, step_count
    );

    modport slave (
        input  multiplicand, multiplier, load, reg_en, shift_en, psel,
        output z_flag_multiplicand, lsb_multiplicand, result, step_count
    );

endinterface

// File: rtl/mult_abs.sv
// Combinational two's-complement magnitude. The most negative input maps to
// 2^(WIDTH-1), which is exact when the output is read as unsigned.
module mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mag
);

    assign mag = value[WIDTH-1] ? (-value) : value;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add datapath of the sequential signed multiplier (sign-magnitude core).
// Optional step counter enabled by defining MULT_DP_STEP_COUNT_EN.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_datapath_if.slave  bus
);

    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [PW-1:0]    mplier_q;
    logic [PW-1:0]    prod_q;
    logic             sign_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH-1:0] mcand_mag;
    logic [WIDTH-1:0] mplier_mag;
    logic             do_load;
    logic             do_step;

    mult_abs #(.WIDTH(WIDTH)) u_abs_mcand  (.value(bus.multiplicand), .mag(mcand_mag));
    mult_abs #(.WIDTH(WIDTH)) u_abs_mplier (.value(bus.multiplier),   .mag(mplier_mag));

    assign do_load = bus.reg_en & bus.load;
    assign do_step = bus.reg_en & ~bus.load & bus.shift_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
        end else if (do_load) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            mcand_q  <= mcand_mag;
            mplier_q <= {{WIDTH{1'b0}}, mplier_mag};
            prod_q   <= '0;
            sign_q   <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
            opnd_q   <= bus.multiplicand;
        end else if (do_step) begin
            if (mcand_q[0]) begin
                prod_q <= prod_q + mplier_q;
            end
            mplier_q <= mplier_q << 1;
            mcand_q  <= mcand_q >> 1;
        end
    end

`ifdef MULT_DP_STEP_COUNT_EN
    logic [7:0] step_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count_q <= '0;
        end else if (do_load) begin
            step_count_q <= '0;
        end else if (do_step && (mcand_q != '0) && (step_count_q != 8'hFF)) begin
            step_count_q <= step_count_q + 8'd1;
        end
    end

    assign bus.step_count = step_count_q;
`else
    assign bus.step_count = 8'd0;
`endif

    // Negating a zero product yields zero, so a negative sign never produces -0.
    assign bus.result = bus.psel ? (sign_q ? (-prod_q) : prod_q)
                                 : {{WIDTH{opnd_q[WIDTH-1]}}, opnd_q};

    assign bus.z_flag_multiplicand = (mcand_q == '0);
    assign bus.lsb_multiplicand    = mcand_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath with hand-computed vectors.
module tb_mult_datapath;
    import mult_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    int   nsteps;

    mult_datapath_if #(.WIDTH(8)) bus ();

    mult_datapath #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_DP_STEP_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.reg_en       = 1'b1;
        bus.load         = 1'b1;
        @(negedge clk);
        bus.reg_en       = 1'b0;
        bus.load         = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            bus.reg_en   = 1'b1;
            bus.shift_en = 1'b1;
            @(negedge clk);
        end
        bus.reg_en   = 1'b0;
        bus.shift_en = 1'b0;
    endtask

    // Step until z_flag rises, bounded so a stuck flag cannot hang the run.
    task automatic run_to_zero(output int n);
        n = 0;
        while (!bus.z_flag_multiplicand && n < 32) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        tests            = 0;
        failed           = 0;
        rst_n            = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.load         = 1'b0;
        bus.reg_en       = 1'b0;
        bus.shift_en     = 1'b0;
        bus.psel         = 1'b1;

        #12;
        check("rst_result", 32'(bus.result), 32'h0000);
        check("rst_zflag",  32'(bus.z_flag_multiplicand), 32'd1);
        check("rst_lsb",    32'(bus.lsb_multiplicand), 32'd0);
        check("rst_count",  32'(bus.step_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 x -3
        load_ops(8'd5, 8'hFD);
        check("p1_zflag_load", 32'(bus.z_flag_multiplicand), 32'd0);
        check("p1_lsb_load",   32'(bus.lsb_multiplicand), 32'd1);
        run_to_zero(nsteps);
        check("p1_steps",  32'(nsteps), 32'd3);
        check("p1_result", 32'(bus.result), 32'hFFF1);
        check("p1_count",  32'(bus.step_count), exp_cnt(3));
        step(1);
        check("p1_exit_result", 32'(bus.result), 32'hFFF1);
        check("p1_exit_count",  32'(bus.step_count), exp_cnt(3));
        bus.psel = 1'b0;
        @(negedge clk);
        check("p1_opnd", 32'(bus.result), 32'h0005);
        bus.psel = 1'b1;

        // -128 x -128
        load_ops(8'h80, 8'h80);
        step(7);
        check("p2_zflag_7", 32'(bus.z_flag_multiplicand), 32'd0);
        step(1);
        check("p2_zflag_8", 32'(bus.z_flag_multiplicand), 32'd1);
        check("p2_result",  32'(bus.result), 32'h4000);
        check("p2_count",   32'(bus.step_count), exp_cnt(8));

        // 0 x 37, then 0 x -37 (negative sign, zero product)
        load_ops(8'd0, 8'd37);
        check("p3_zflag_load", 32'(bus.z_flag_multiplicand), 32'd1);
        step(1);
        check("p3_result", 32'(bus.result), 32'h0000);
        check("p3_count",  32'(bus.step_count), 32'd0);
        load_ops(8'd0, 8'hDB);
        step(1);
        check("p3n_result", 32'(bus.result), 32'h0000);

        // 7 x 9 interrupted after 2 steps by -2 x 6
        load_ops(8'd7, 8'd9);
        step(2);
        check("p4_partial", 32'(bus.result), 32'd27);
        load_ops(8'hFE, 8'd6);
        check("p4_cleared", 32'(bus.result), 32'h0000);
        run_to_zero(nsteps);
        check("p4_steps",  32'(nsteps), 32'd2);
        check("p4_result", 32'(bus.result), 32'hFFF4);
        check("p4_count",  32'(bus.step_count), exp_cnt(2));
        bus.psel = 1'b0;
        @(negedge clk);
        check("p4_opnd", 32'(bus.result), 32'hFFFE);
        bus.psel = 1'b1;

        // reg_en low blocks shift_en
        load_ops(8'd5, 8'hFD);
        step(1);
        bus.reg_en   = 1'b0;
        bus.shift_en = 1'b1;
        repeat (5) @(negedge clk);
        bus.shift_en = 1'b0;
        check("hold_result", 32'(bus.result), 32'hFFFD);
        check("hold_lsb",    32'(bus.lsb_multiplicand), 32'd0);
        check("hold_zflag",  32'(bus.z_flag_multiplicand), 32'd0);
        check("hold_count",  32'(bus.step_count), exp_cnt(1));

        // asynchronous reset mid-run, checked before any clock edge
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", 32'(bus.result), 32'h0000);
        check("arst_zflag",  32'(bus.z_flag_multiplicand), 32'd1);
        check("arst_count",  32'(bus.step_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
